// File: rtl/xbar_cluster_demux_n.sv
// rtl/xbar_cluster_demux_n.sv - 1-to-NB_SLAVE cluster bus demux with in-order responses
// Address decode, outstanding tracking, and an internal error responder for unmapped addresses.
module xbar_cluster_demux_n #(
  parameter int NB_SLAVE        = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ATOP_WIDTH      = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hBADACCE5,
  localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           core_req_i,
  input  logic [ADDR_WIDTH-1:0]          core_add_i,
  input  logic                           core_we_i,
  input  logic [ATOP_WIDTH-1:0]          core_atop_i,
  input  logic [DATA_WIDTH-1:0]          core_wdata_i,
  input  logic [BE_WIDTH-1:0]            core_be_i,
  input  logic                           core_barrier_i,
  input  logic                           core_exec_stall_i,
  input  logic                           core_exec_cancel_i,
  output logic                           core_gnt_o,
  output logic                           core_busy_o,
  input  logic                           core_r_gnt_i,
  output logic                           core_r_valid_o,
  output logic [DATA_WIDTH-1:0]          core_r_rdata_o,
  output logic                           core_r_err_o,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] rule_base_i,
  input  logic [NB_SLAVE*ADDR_WIDTH-1:0] rule_mask_i,
  output logic [NB_SLAVE-1:0]            slv_req_o,
  output logic [NB_SLAVE*ADDR_WIDTH-1:0] slv_add_o,
  output logic [NB_SLAVE-1:0]            slv_we_o,
  output logic [NB_SLAVE*ATOP_WIDTH-1:0] slv_atop_o,
  output logic [NB_SLAVE*DATA_WIDTH-1:0] slv_wdata_o,
  output logic [NB_SLAVE*BE_WIDTH-1:0]   slv_be_o,
  input  logic [NB_SLAVE-1:0]            slv_gnt_i,
  output logic [NB_SLAVE-1:0]            slv_r_gnt_o,
  input  logic [NB_SLAVE-1:0]            slv_r_valid_i,
  input  logic [NB_SLAVE*DATA_WIDTH-1:0] slv_r_rdata_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TGT_W = $clog2(NB_SLAVE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NB_SLAVE);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TGT_W-1:0]      cur_tgt_q, cur_tgt_d;
  logic                  err_pend_q, err_pend_d;
  logic [TGT_W-1:0]      tgt;
  logic                  tgt_gnt;
  logic                  allow;
  logic                  accept;
  logic                  beat;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  cur_is_err;

  // Descending scan so the lowest matching index overrides higher ones.
  always_comb begin
    tgt = ERR_TGT;
    for (int i = NB_SLAVE - 1; i >= 0; i--) begin
      if ((core_add_i & rule_mask_i[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          rule_base_i[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        tgt = TGT_W'(i);
      end
    end
  end

  always_comb begin
    tgt_gnt = 1'b0;
    if (tgt == ERR_TGT) begin
      tgt_gnt = ~err_pend_q;
    end else begin
      for (int i = 0; i < NB_SLAVE; i++) begin
        if (tgt == TGT_W'(i)) tgt_gnt = slv_gnt_i[i];
      end
    end
  end

  // Switching targets waits for a full drain so responses come back in request order.
  assign allow = core_req_i & ~core_exec_cancel_i & ~core_exec_stall_i
               & ~(core_barrier_i & (cnt_q != '0)) & (cnt_q < MAX_CNT)
               & ((cnt_q == '0) | (tgt == cur_tgt_q)) & ~rst_i;

  assign core_gnt_o  = allow & tgt_gnt;
  assign core_busy_o = (cnt_q != '0);

  always_comb begin
    for (int i = 0; i < NB_SLAVE; i++) begin
      slv_req_o[i] = allow & (tgt == TGT_W'(i));
    end
  end

  assign slv_add_o   = {NB_SLAVE{core_add_i}};
  assign slv_we_o    = {NB_SLAVE{core_we_i}};
  assign slv_atop_o  = {NB_SLAVE{core_atop_i}};
  assign slv_wdata_o = {NB_SLAVE{core_wdata_i}};
  assign slv_be_o    = {NB_SLAVE{core_be_i}};

  assign cur_is_err = (cur_tgt_q == ERR_TGT);

  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    if (cur_is_err) begin
      sel_valid = err_pend_q;
      sel_rdata = ERR_RDATA;
    end else begin
      for (int i = 0; i < NB_SLAVE; i++) begin
        if (cur_tgt_q == TGT_W'(i)) begin
          sel_valid = slv_r_valid_i[i];
          sel_rdata = slv_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign core_r_valid_o = sel_valid & (cnt_q != '0) & ~rst_i;
  assign core_r_rdata_o = rst_i ? '0 : sel_rdata;
  assign core_r_err_o   = core_r_valid_o & cur_is_err;

  // Non-current ports are always ready so stray responses are discarded.
  always_comb begin
    for (int i = 0; i < NB_SLAVE; i++) begin
      if (rst_i) begin
        slv_r_gnt_o[i] = 1'b0;
      end else if (cur_tgt_q == TGT_W'(i)) begin
        slv_r_gnt_o[i] = core_r_gnt_i;
      end else begin
        slv_r_gnt_o[i] = 1'b1;
      end
    end
  end

  assign accept = core_req_i & core_gnt_o;
  assign beat   = core_r_valid_o & core_r_gnt_i;

  always_comb begin
    cnt_d      = cnt_q;
    cur_tgt_d  = cur_tgt_q;
    err_pend_d = err_pend_q;
    if (accept && !beat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && beat) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (accept) begin
      cur_tgt_d = tgt;
    end
    if (accept && (tgt == ERR_TGT)) begin
      err_pend_d = 1'b1;
    end else if (beat && cur_is_err) begin
      err_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      cur_tgt_q  <= '0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_tgt_q  <= cur_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

endmodule
